// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch/decode/execute/memory/write-back and drives the enable strobes.
module cpu_sequencer #(
    parameter int OPW        = 6,
    parameter int MC_TIMEOUT = 64,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            im_ready,
    input  logic            alu_done,
    input  logic            dm_ready,
    output logic            ir_we,
    output logic            pc_we,
    output logic            rf_we,
    output logic            alu_start,
    output logic            dm_re,
    output logic            dm_we,
    output logic            halted,
    output logic            fault,
    output logic [3:0]      state,
    output logic [CNTW-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MWAIT  = 4'd4,
        S_MEM    = 4'd5,
        S_WB     = 4'd6,
        S_HALT   = 4'd7,
        S_FAULT  = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_mc_cnt;
    logic [CNTW-1:0] r_retired;
    logic            w_retire;

    logic w_is_halt;
    logic w_is_multi;
    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;

    // Opcodes 32-63 fall through every class test and run as single-cycle ALU.
    assign w_is_halt   = (opcode == OPW'(0));
    assign w_is_multi  = (opcode == OPW'(3))  || (opcode == OPW'(4)) ||
                         (opcode == OPW'(20)) || (opcode == OPW'(21));
    assign w_is_load   = (opcode == OPW'(24)) || (opcode == OPW'(26));
    assign w_is_store  = (opcode == OPW'(25)) || (opcode == OPW'(27));
    assign w_is_branch = (opcode >= OPW'(28)) && (opcode <= OPW'(31));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mc_cnt  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Counter only runs inside MWAIT, so EXEC always hands over a cleared count.
            if (r_state == S_MWAIT) r_mc_cnt <= r_mc_cnt + 8'd1;
            else                    r_mc_cnt <= '0;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        alu_start = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        w_retire  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (im_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (w_is_multi) begin
                    alu_start = 1'b1;
                    w_next    = S_MWAIT;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (w_is_branch) begin
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MWAIT: begin
                // A done arriving in the final timeout cycle still completes normally.
                if (alu_done)                            w_next = S_WB;
                else if (r_mc_cnt == 8'(MC_TIMEOUT - 1)) w_next = S_FAULT;
            end
            S_MEM: begin
                dm_re = w_is_load;
                dm_we = w_is_store;
                if (dm_ready) begin
                    if (w_is_store) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                if (run) begin
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign state   = r_state;
    assign halted  = (r_state == S_HALT) || (r_state == S_FAULT);
    assign fault   = (r_state == S_FAULT);
    assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected strobe events,
// a negedge monitor pops and compares whenever any strobe is active.
module tb_cpu_sequencer;

    localparam int CW = 4;  // narrow counter so the wrap is reachable quickly

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_EXEC = 4'd3, S_MWAIT = 4'd4, S_MEM = 4'd5,
                           S_WB = 4'd6, S_HALT = 4'd7, S_FAULT = 4'd8;

    localparam logic [5:0] SB_IR = 6'b100000, SB_PC = 6'b010000,
                           SB_RF = 6'b001000, SB_AS = 6'b000100,
                           SB_RE = 6'b000010, SB_WE = 6'b000001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [5:0]    opcode;
    logic          im_ready;
    logic          alu_done;
    logic          dm_ready;
    logic          ir_we, pc_we, rf_we, alu_start, dm_re, dm_we;
    logic          halted, fault;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] ret      = '0;
    logic [4+6+CW-1:0] exp_q[$];

    cpu_sequencer #(
        .OPW       (6),
        .MC_TIMEOUT(64),
        .CNTW      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .opcode   (opcode),
        .im_ready (im_ready),
        .alu_done (alu_done),
        .dm_ready (dm_ready),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .rf_we    (rf_we),
        .alu_start(alu_start),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .halted   (halted),
        .fault    (fault),
        .state    (state),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [5:0] sb, input logic [CW-1:0] rt);
        exp_q.push_back({st, sb, rt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: DUT sits in FETCH with im_ready low.  Leaves it one state past DECODE.
    task automatic fetch_decode(input logic [5:0] op);
        push(S_FETCH, SB_IR, ret);
        opcode   = op;
        im_ready = 1'b1;
        tick();
        im_ready = 1'b0;
        chk("decode_state", state, S_DECODE);
        tick();
    endtask

    // Monitor: any active strobe is a DUT output event to match against the queue.
    always @(negedge clk) begin
        logic [5:0]        sb;
        logic [4+6+CW-1:0] e;
        sb = {ir_we, pc_we, rf_we, alu_start, dm_re, dm_we};
        if (sb != 6'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got state=%0d strobes=%b retired=%0d expected no strobe",
                         state, sb, retired);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_event", 32'({state, sb, retired}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0;
        im_ready = 1'b0; alu_done = 1'b0; dm_ready = 1'b0;
        tick(); tick();
        chk("reset_state", state, S_IDLE);
        chk("reset_halted", halted, 1'b0);
        chk("reset_fault", fault, 1'b0);
        chk("reset_retired", retired, '0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", state, S_IDLE);

        // Single-cycle ALU, opcode 5: 1,2,3,6,1
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_to_fetch", state, S_FETCH);
        fetch_decode(6'd5);
        chk("alu_exec", state, S_EXEC);
        tick();
        chk("alu_wb", state, S_WB);
        push(S_WB, SB_PC | SB_RF, ret);
        tick();
        ret++;
        chk("alu_back_fetch", state, S_FETCH);
        chk("alu_retired", retired, 32'(ret));

        // Multi-cycle opcode 3, done on 3rd MWAIT cycle
        fetch_decode(6'd3);
        push(S_EXEC, SB_AS, ret);
        tick();
        chk("mul_mwait1", state, S_MWAIT);
        tick(); tick();
        chk("mul_mwait3", state, S_MWAIT);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("mul_wb", state, S_WB);
        push(S_WB, SB_PC | SB_RF, ret);
        tick();
        ret++;
        chk("mul_retired", retired, 32'(ret));

        // Load opcode 24, dm_ready after 2 wait cycles; stray alu_done must be ignored
        alu_done = 1'b1;
        fetch_decode(6'd24);
        alu_done = 1'b0;
        tick();
        chk("load_mem", state, S_MEM);
        push(S_MEM, SB_RE, ret);
        tick();
        push(S_MEM, SB_RE, ret);
        tick();
        push(S_MEM, SB_RE, ret);
        dm_ready = 1'b1;
        tick();
        dm_ready = 1'b0;
        chk("load_wb", state, S_WB);
        push(S_WB, SB_PC | SB_RF, ret);
        tick();
        ret++;
        chk("load_retired", retired, 32'(ret));

        // Store opcode 25
        fetch_decode(6'd25);
        tick();
        push(S_MEM, SB_WE, ret);
        tick();
        push(S_MEM, SB_WE | SB_PC, ret);
        dm_ready = 1'b1;
        tick();
        dm_ready = 1'b0;
        ret++;
        chk("store_fetch", state, S_FETCH);
        chk("store_retired", retired, 32'(ret));

        // Opcode 21: alu_done lands exactly in the 64th MWAIT cycle, completion wins
        fetch_decode(6'd21);
        push(S_EXEC, SB_AS, ret);
        tick();
        repeat (63) tick();
        chk("edge_mwait64", state, S_MWAIT);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("edge_wb", state, S_WB);
        chk("edge_nofault", fault, 1'b0);
        push(S_WB, SB_PC | SB_RF, ret);
        tick();
        ret++;

        // Opcode 20: no alu_done, FAULT after 64 MWAIT cycles
        fetch_decode(6'd20);
        push(S_EXEC, SB_AS, ret);
        tick();
        repeat (63) tick();
        chk("to_mwait64", state, S_MWAIT);
        tick();
        chk("to_fault_state", state, S_FAULT);
        chk("to_halted", halted, 1'b1);
        chk("to_fault", fault, 1'b1);
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        chk("fault_ignores_run", state, S_FAULT);
        chk("fault_sticky", fault, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ret = '0;
        chk("fault_reset_state", state, S_IDLE);
        chk("fault_reset_flag", fault, 1'b0);
        chk("fault_reset_retired", retired, '0);

        // HALT and resume
        run = 1'b1;
        tick();
        run = 1'b0;
        fetch_decode(6'd0);
        chk("halt_state", state, S_HALT);
        chk("halt_halted", halted, 1'b1);
        chk("halt_nofault", fault, 1'b0);
        tick();
        chk("halt_stays", state, S_HALT);
        push(S_HALT, SB_PC, ret);
        run = 1'b1;
        tick();
        run = 1'b0;
        ret++;
        chk("resume_fetch", state, S_FETCH);
        chk("resume_retired", retired, 32'(ret));

        // Reset in the middle of a load
        fetch_decode(6'd26);
        tick();
        chk("rstmem_mem", state, S_MEM);
        push(S_MEM, SB_RE, ret);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ret = '0;
        chk("rstmem_state", state, S_IDLE);
        chk("rstmem_dm_re", dm_re, 1'b0);

        // Branches until the counter wraps
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < (1 << CW); i++) begin
            fetch_decode(6'(28 + (i % 4)));
            push(S_EXEC, SB_PC, ret);
            tick();
            ret++;
            if (i == (1 << CW) - 2) chk("wrap_allones", retired, 32'((1 << CW) - 1));
        end
        chk("wrap_zero", retired, '0);
        chk("wrap_state", state, S_FETCH);

        tick(); tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
